// File: rtl/glyph_plotter.sv
// Draws one 4x4 glyph cell (letter, blank or underscore) as 16 consecutive VGA pixel writes.
// Every cell pixel is written, foreground or background, so the previous cell content is erased.
module glyph_plotter #(
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       show,
  input  logic [7:0] ascii,
  input  logic [6:0] sx,
  input  logic [6:0] sy,
  input  logic [2:0] fg_colour,
  output logic [6:0] outx,
  output logic [6:0] outy,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  // Row r of the glyph is nibble r (top row in bits 3:0); bit dx within the nibble.
  function automatic logic [15:0] font_rom(input logic [4:0] idx);
    logic [15:0] bm;
    case (idx)
      5'd0:  bm = 16'h9F96; 5'd1:  bm = 16'h7977; 5'd2:  bm = 16'hE11E;
      5'd3:  bm = 16'h7997; 5'd4:  bm = 16'hF17F; 5'd5:  bm = 16'h117F;
      5'd6:  bm = 16'hE9DE; 5'd7:  bm = 16'h9F99; 5'd8:  bm = 16'h7227;
      5'd9:  bm = 16'h698C; 5'd10: bm = 16'h9539; 5'd11: bm = 16'hF111;
      5'd12: bm = 16'h9BF9; 5'd13: bm = 16'h9DB9; 5'd14: bm = 16'h6996;
      5'd15: bm = 16'h1797; 5'd16: bm = 16'hE996; 5'd17: bm = 16'h9797;
      5'd18: bm = 16'h7C3E; 5'd19: bm = 16'h222F; 5'd20: bm = 16'h6999;
      5'd21: bm = 16'h6699; 5'd22: bm = 16'h9FB9; 5'd23: bm = 16'h9669;
      5'd24: bm = 16'h2269; 5'd25: bm = 16'hF24F;
      default: bm = 16'h0000;
    endcase
    return bm;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  sx_q, sx_d, sy_q, sy_d;
  logic [2:0]  fg_q, fg_d;
  logic [15:0] bm_q, bm_d;
  logic [6:0]  outx_q, outx_d, outy_q, outy_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]  letter_off;
  logic [15:0] sel_bm;

  always_comb begin
    letter_off = ascii - 8'h41;
    if (!show)
      sel_bm = 16'hF000;
    else if (ascii >= 8'h41 && ascii <= 8'h5A)
      sel_bm = font_rom(letter_off[4:0]);
    else
      sel_bm = 16'h0000;
  end

  always_comb begin
    // NOTE: every _d gets a default first, so no path through the case can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    fg_d     = fg_q;
    bm_d     = bm_q;
    outx_d   = outx_q;
    outy_d   = outy_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        sx_d    = sx;
        sy_d    = sy;
        fg_d    = fg_colour;
        bm_d    = sel_bm;
        cnt_d   = 4'd0;
        state_d = DRAW;
      end
      DRAW: begin
        outx_d   = sx_q + {5'd0, cnt_q[1:0]};
        outy_d   = sy_q + {5'd0, cnt_q[3:2]};
        colour_d = bm_q[cnt_q] ? fg_q : BG_COLOUR;
        plot_d   = 1'b1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      sx_q     <= 7'd0;
      sy_q     <= 7'd0;
      fg_q     <= 3'd0;
      bm_q     <= 16'h0000;
      outx_q   <= 7'd0;
      outy_q   <= 7'd0;
      colour_q <= 3'd0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      fg_q     <= fg_d;
      bm_q     <= bm_d;
      outx_q   <= outx_d;
      outy_q   <= outy_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign outx   = outx_q;
  assign outy   = outy_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_glyph_plotter.sv
// Directed bench for glyph_plotter: pixel order, colours, coordinate wrap, busy-ignore and async abort.
module tb_glyph_plotter;

  logic       clk = 1'b0;
  logic       resetn, start, show;
  logic [7:0] ascii;
  logic [6:0] sx, sy, outx, outy;
  logic [2:0] fg_colour, colour;
  logic       plot, busy, done;

  int total_cnt = 0;
  int pass_cnt  = 0;

  glyph_plotter #(.BG_COLOUR(3'b000)) dut (
    .clk(clk), .resetn(resetn), .start(start), .show(show), .ascii(ascii),
    .sx(sx), .sy(sy), .fg_colour(fg_colour), .outx(outx), .outy(outy),
    .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; show = 1'b0; ascii = 8'h00;
    sx = 7'd0; sy = 7'd0; fg_colour = 3'd0;
    #1;
    total_cnt++;
    if ({outx, outy, colour, plot, busy, done} !== 20'd0)
      $display("FAIL reset_outputs got %h want 0", {outx, outy, colour, plot, busy, done});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({plot, busy, done} !== 3'b000)
      $display("FAIL reset_release_idle got %b want 000", {plot, busy, done});
    else pass_cnt++;
  endtask

  // Launches one glyph and checks every cycle until it is finished (or aborted by reset_at).
  task automatic draw_check(input string name, input logic sh, input logic [7:0] asc,
                            input logic [6:0] x0, input logic [6:0] y0, input logic [2:0] fg,
                            input logic [15:0] exp_bm, input int disturb_at, input int reset_at);
    logic [6:0] ex, ey;
    logic [2:0] ec;
    logic [3:0] c;
    @(negedge clk);
    show = sh; ascii = asc; sx = x0; sy = y0; fg_colour = fg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || plot !== 1'b0)
      $display("FAIL %s load_busy busy/plot got %b%b want 10", name, busy, plot);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (plot !== 1'b0)
      $display("FAIL %s no_early_plot got %b want 0", name, plot);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      c  = 4'(k);
      ex = x0 + {5'd0, c[1:0]};
      ey = y0 + {5'd0, c[3:2]};
      ec = exp_bm[k] ? fg : 3'b000;
      total_cnt++;
      if (plot !== 1'b1 || outx !== ex || outy !== ey || colour !== ec || busy !== 1'b1)
        $display("FAIL %s pixel%0d plot/x/y/col/busy got %b/%0d/%0d/%b/%b want 1/%0d/%0d/%b/1",
                 name, k, plot, outx, outy, colour, busy, ex, ey, ec);
      else pass_cnt++;
      if (k == disturb_at) begin
        start = 1'b1; sx = x0 + 7'd40; sy = y0 + 7'd9; show = ~sh; fg_colour = ~fg;
      end else if (k == disturb_at + 1) begin
        start = 1'b0;
      end
      if (k == reset_at) begin
        resetn = 1'b0;
        #1;
        total_cnt++;
        if ({outx, outy, colour, plot, busy, done} !== 20'd0)
          $display("FAIL %s async_abort got %h want 0", name, {outx, outy, colour, plot, busy, done});
        else pass_cnt++;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          total_cnt++;
          if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s post_abort_idle%0d plot/done/busy got %b%b%b want 000",
                     name, j, plot, done, busy);
          else pass_cnt++;
        end
        return;
      end
    end
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b1 || plot !== 1'b0)
      $display("FAIL %s done_pulse done/plot got %b%b want 10", name, done, plot);
    else pass_cnt++;
    @(negedge clk);
    ex = x0 + 7'd3;
    ey = y0 + 7'd3;
    total_cnt++;
    if (done !== 1'b0 || plot !== 1'b0 || busy !== 1'b0 || outx !== ex || outy !== ey)
      $display("FAIL %s after_done done/plot/busy/x/y got %b%b%b/%0d/%0d want 000/%0d/%0d",
               name, done, plot, busy, outx, outy, ex, ey);
    else pass_cnt++;
  endtask

  task automatic test_underscore();
    draw_check("underscore", 1'b0, 8'h41, 7'd10, 7'd20, 3'b111, 16'hF000, -1, -1);
  endtask

  task automatic test_letter_a();
    draw_check("letter_a", 1'b1, 8'h41, 7'd0, 7'd0, 3'b010, 16'h9F96, -1, -1);
  endtask

  task automatic test_wrap();
    draw_check("wrap", 1'b0, 8'h00, 7'd126, 7'd127, 3'b101, 16'hF000, -1, -1);
  endtask

  task automatic test_blank_ignore();
    draw_check("blank_ignore", 1'b1, 8'h30, 7'd50, 7'd60, 3'b110, 16'h0000, 5, -1);
  endtask

  task automatic test_reset_mid_draw();
    draw_check("abort", 1'b1, 8'h41, 7'd30, 7'd40, 3'b011, 16'h9F96, -1, 7);
    draw_check("after_abort", 1'b0, 8'h5A, 7'd31, 7'd41, 3'b100, 16'hF000, -1, -1);
  endtask

  task automatic test_back_to_back();
    draw_check("b2b_first", 1'b1, 8'h41, 7'd5, 7'd6, 3'b001, 16'h9F96, -1, -1);
    draw_check("b2b_second", 1'b1, 8'h5B, 7'd100, 7'd3, 3'b111, 16'h0000, -1, -1);
  endtask

  initial begin
    test_reset();
    test_underscore();
    test_letter_a();
    test_wrap();
    test_blank_ignore();
    test_reset_mid_draw();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
